// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 8051-compatible ALU slice.
// Contents: datapath/opcode widths, opcode constants (ALU_NOP .. ALU_ORLN_C)
// and the packed result record carried from the combinational stage to the
// output registers.
package alu_pkg;

  localparam int OPC_W  = 5;
  localparam int DATA_W = 8;

  localparam logic [OPC_W-1:0] ALU_NOP    = 5'd0;
  localparam logic [OPC_W-1:0] ALU_ADD    = 5'd1;
  localparam logic [OPC_W-1:0] ALU_ADDC   = 5'd2;
  localparam logic [OPC_W-1:0] ALU_SUBB   = 5'd3;
  localparam logic [OPC_W-1:0] ALU_INC    = 5'd4;
  localparam logic [OPC_W-1:0] ALU_DEC    = 5'd5;
  localparam logic [OPC_W-1:0] ALU_MUL    = 5'd6;
  localparam logic [OPC_W-1:0] ALU_DIV    = 5'd7;
  localparam logic [OPC_W-1:0] ALU_DA     = 5'd8;
  localparam logic [OPC_W-1:0] ALU_CPL    = 5'd9;
  localparam logic [OPC_W-1:0] ALU_ANL    = 5'd10;
  localparam logic [OPC_W-1:0] ALU_ORL    = 5'd11;
  localparam logic [OPC_W-1:0] ALU_XRL    = 5'd12;
  localparam logic [OPC_W-1:0] ALU_RL     = 5'd13;
  localparam logic [OPC_W-1:0] ALU_RLC    = 5'd14;
  localparam logic [OPC_W-1:0] ALU_RR     = 5'd15;
  localparam logic [OPC_W-1:0] ALU_RRC    = 5'd16;
  localparam logic [OPC_W-1:0] ALU_SWAP   = 5'd17;
  localparam logic [OPC_W-1:0] ALU_ANL_C  = 5'd18;
  localparam logic [OPC_W-1:0] ALU_ORL_C  = 5'd19;
  localparam logic [OPC_W-1:0] ALU_ANLN_C = 5'd20;
  localparam logic [OPC_W-1:0] ALU_ORLN_C = 5'd21;

  typedef struct packed {
    logic [DATA_W-1:0] out_1;
    logic [DATA_W-1:0] out_2;
    logic              cy;
    logic              ac;
    logic              ov;
  } alu_res_t;

endpackage

// File: rtl/alu_core_unit_if.sv
// alu_core_unit_if: operand/result bundle between the decoder/register file
// and the ALU.
//   alu_opcode   (5)  operation select
//   op_in_1/2    (8)  operands (accumulator side / B, register, immediate)
//   carry_in, aux_carry_in, bit_in  PSW.CY, PSW.AC, Boolean bit operand
//   op_out_1/2   (8)  primary / secondary result bytes
//   carry_out, aux_carry_out, overflow_out  new CY / AC / OV
// master: the side driving opcode and operands; slave: the ALU.
interface alu_core_unit_if;
  import alu_pkg::*;

  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] op_in_1;
  logic [DATA_W-1:0] op_in_2;
  logic              carry_in;
  logic              aux_carry_in;
  logic              bit_in;
  logic [DATA_W-1:0] op_out_1;
  logic [DATA_W-1:0] op_out_2;
  logic              carry_out;
  logic              aux_carry_out;
  logic              overflow_out;

  modport master (
    output alu_opcode, op_in_1, op_in_2, carry_in, aux_carry_in, bit_in,
    input  op_out_1, op_out_2, carry_out, aux_carry_out, overflow_out
  );

  modport slave (
    input  alu_opcode, op_in_1, op_in_2, carry_in, aux_carry_in, bit_in,
    output op_out_1, op_out_2, carry_out, aux_carry_out, overflow_out
  );

endinterface

// File: rtl/alu_divider.sv
// alu_divider: combinational 8/8 unsigned restoring divider.
//   dividend, divisor (8) in
//   quotient, remainder (8) out; both forced to 0xFF on divide-by-zero
//   div_zero (1) out, set when divisor is zero
module alu_divider
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_zero
);

  logic [DATA_W:0]   rem_w;
  logic [DATA_W-1:0] quo_w;

  always_comb begin
    rem_w = '0;
    quo_w = '0;
    // One shift/compare/subtract step per quotient bit, MSB first.
    for (int i = DATA_W - 1; i >= 0; i--) begin
      rem_w = {rem_w[DATA_W-1:0], dividend[i]};
      if (rem_w >= {1'b0, divisor}) begin
        rem_w    = rem_w - {1'b0, divisor};
        quo_w[i] = 1'b1;
      end
    end
    div_zero = (divisor == '0);
    if (div_zero) begin
      quotient  = '1;
      remainder = '1;
    end else begin
      quotient  = quo_w;
      remainder = rem_w[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/alu_core_unit.sv
// alu_core_unit: registered 8-bit ALU of the 8051-compatible core.
// Result and flags are computed combinationally from the current opcode and
// operands and captured into the output registers on the rising clock edge
// (latency one cycle, a new operation every cycle, no handshake).
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low; clears every output register
//   bus    alu_core_unit_if.slave (opcode, operands, PSW bits in; results out)
// Build option: define ALU_MULDIV_EN to implement MUL (6) and DIV (7);
// without it both opcodes behave as NOP and no multiplier/divider exists.
module alu_core_unit
  import alu_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  alu_core_unit_if.slave bus
);

  logic [DATA_W-1:0]        a_p0;
  logic [DATA_W-1:0]        b_p0;
  logic                     cin_add_p0;
  logic [DATA_W:0]          sum_p0;
  logic [DATA_W:0]          diff_p0;
  logic signed [DATA_W:0]   ssum_p0;
  logic signed [DATA_W:0]   sdiff_p0;
  alu_res_t                 res_p0;
  alu_res_t                 res_p1;

  // Decimal adjust: returns {new CY, adjusted byte}. CY can only be set here.
  function automatic logic [DATA_W:0] da_adjust(input logic [DATA_W-1:0] a,
                                                input logic ac, input logic cy);
    logic [DATA_W:0] t1;
    logic [DATA_W:0] t2;
    t1 = {1'b0, a} + (((a[3:0] > 4'd9) || ac) ? 9'h006 : 9'h000);
    t2 = {1'b0, t1[7:0]} + (((t1[7:4] > 4'd9) || cy || t1[8]) ? 9'h060 : 9'h000);
    return {cy | t1[8] | t2[8], t2[7:0]};
  endfunction

  // Signed overflow of a 9-bit sign-extended byte result.
  function automatic logic ovf8(input logic signed [DATA_W:0] v);
    return (v > 9'sd127) || (v < -9'sd128);
  endfunction

  assign a_p0       = bus.op_in_1;
  assign b_p0       = bus.op_in_2;
  assign cin_add_p0 = (bus.alu_opcode == ALU_ADDC) & bus.carry_in;

  assign sum_p0   = {1'b0, a_p0} + {1'b0, b_p0} + {8'd0, cin_add_p0};
  assign diff_p0  = {1'b0, a_p0} - {1'b0, b_p0} - {8'd0, bus.carry_in};
  assign ssum_p0  = $signed({a_p0[7], a_p0}) + $signed({b_p0[7], b_p0})
                  + $signed({8'd0, cin_add_p0});
  assign sdiff_p0 = $signed({a_p0[7], a_p0}) - $signed({b_p0[7], b_p0})
                  - $signed({8'd0, bus.carry_in});

`ifdef ALU_MULDIV_EN
  logic [2*DATA_W-1:0] prod_p0;
  logic [DATA_W-1:0]   quo_p0;
  logic [DATA_W-1:0]   rem_p0;
  logic                dz_p0;

  assign prod_p0 = {8'd0, a_p0} * {8'd0, b_p0};

  alu_divider u_divider (
    .dividend  (a_p0),
    .divisor   (b_p0),
    .quotient  (quo_p0),
    .remainder (rem_p0),
    .div_zero  (dz_p0)
  );
`endif

  // Stage p0: combinational result selection
  always_comb begin
    res_p0.out_1 = a_p0;
    res_p0.out_2 = '0;
    res_p0.cy    = bus.carry_in;
    res_p0.ac    = bus.aux_carry_in;
    res_p0.ov    = 1'b0;
    case (bus.alu_opcode)
      ALU_ADD, ALU_ADDC: begin
        res_p0.out_1 = sum_p0[7:0];
        res_p0.cy    = sum_p0[8];
        // Carry into bit 4 equals a4 ^ b4 ^ sum4.
        res_p0.ac    = a_p0[4] ^ b_p0[4] ^ sum_p0[4];
        res_p0.ov    = ovf8(ssum_p0);
      end
      ALU_SUBB: begin
        res_p0.out_1 = diff_p0[7:0];
        res_p0.cy    = diff_p0[8];
        res_p0.ac    = a_p0[4] ^ b_p0[4] ^ diff_p0[4];
        res_p0.ov    = ovf8(sdiff_p0);
      end
      ALU_INC: res_p0.out_1 = a_p0 + 8'd1;
      ALU_DEC: res_p0.out_1 = a_p0 - 8'd1;
`ifdef ALU_MULDIV_EN
      ALU_MUL: begin
        res_p0.out_1 = prod_p0[7:0];
        res_p0.out_2 = prod_p0[15:8];
        res_p0.cy    = 1'b0;
        res_p0.ov    = (prod_p0[15:8] != 8'd0);
      end
      ALU_DIV: begin
        res_p0.out_1 = quo_p0;
        res_p0.out_2 = rem_p0;
        res_p0.cy    = 1'b0;
        res_p0.ov    = dz_p0;
      end
`endif
      ALU_DA:     {res_p0.cy, res_p0.out_1} = da_adjust(a_p0, bus.aux_carry_in, bus.carry_in);
      ALU_CPL:    res_p0.out_1 = ~a_p0;
      ALU_ANL:    res_p0.out_1 = a_p0 & b_p0;
      ALU_ORL:    res_p0.out_1 = a_p0 | b_p0;
      ALU_XRL:    res_p0.out_1 = a_p0 ^ b_p0;
      ALU_RL:     res_p0.out_1 = {a_p0[6:0], a_p0[7]};
      ALU_RLC: begin
        res_p0.out_1 = {a_p0[6:0], bus.carry_in};
        res_p0.cy    = a_p0[7];
      end
      ALU_RR:     res_p0.out_1 = {a_p0[0], a_p0[7:1]};
      ALU_RRC: begin
        res_p0.out_1 = {bus.carry_in, a_p0[7:1]};
        res_p0.cy    = a_p0[0];
      end
      ALU_SWAP:   res_p0.out_1 = {a_p0[3:0], a_p0[7:4]};
      ALU_ANL_C:  res_p0.cy = bus.carry_in & bus.bit_in;
      ALU_ORL_C:  res_p0.cy = bus.carry_in | bus.bit_in;
      ALU_ANLN_C: res_p0.cy = bus.carry_in & ~bus.bit_in;
      ALU_ORLN_C: res_p0.cy = bus.carry_in | ~bus.bit_in;
      default: ;
    endcase
  end

  // Stage p1: output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_p1 <= '0;
    end else begin
      res_p1 <= res_p0;
    end
  end

  assign bus.op_out_1      = res_p1.out_1;
  assign bus.op_out_2      = res_p1.out_2;
  assign bus.carry_out     = res_p1.cy;
  assign bus.aux_carry_out = res_p1.ac;
  assign bus.overflow_out  = res_p1.ov;

endmodule

// File: tb/tb_alu_core_unit.sv
// tb_alu_core_unit: directed-vector bench for alu_core_unit with an
// arithmetic reference model, a per-cycle compare process and literal pins.
module tb_alu_core_unit;
  import alu_pkg::*;

  logic clock;
  logic reset;
  alu_core_unit_if bus();

  alu_core_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [18:0] exp_res = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: {out1, out2, cy, ac, ov} from plain integer arithmetic.
  function automatic logic [18:0] model(input int opc, input int a, input int b,
                                        input bit c, input bit acin, input bit bi);
    int o1, o2, s, t, sa, sb, ci, c1;
    bit cy, ac, ov;
    o1 = a; o2 = 0; cy = c; ac = acin; ov = 0;
    ci = c ? 1 : 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (opc)
      1, 2: begin
        if (opc == 1) ci = 0;
        s  = a + b + ci;
        o1 = s % 256;
        cy = (s > 255);
        ac = ((a % 16) + (b % 16) + ci) > 15;
        t  = sa + sb + ci;
        ov = (t > 127) || (t < -128);
      end
      3: begin
        s  = a - b - ci;
        o1 = (s + 256) % 256;
        cy = (s < 0);
        ac = ((a % 16) - (b % 16) - ci) < 0;
        t  = sa - sb - ci;
        ov = (t > 127) || (t < -128);
      end
      4: o1 = (a + 1) % 256;
      5: o1 = (a + 255) % 256;
`ifdef ALU_MULDIV_EN
      6: begin
        s = a * b; o1 = s % 256; o2 = s / 256; cy = 0; ov = (s > 255);
      end
      7: begin
        cy = 0;
        if (b == 0) begin o1 = 255; o2 = 255; ov = 1; end
        else begin o1 = a / b; o2 = a % b; ov = 0; end
      end
`endif
      8: begin
        s = a; c1 = 0;
        if ((a % 16) > 9 || acin) s = s + 6;
        if (s > 255) begin c1 = 1; s = s - 256; end
        if ((s / 16) > 9 || c || c1 != 0) s = s + 96;
        cy = c || (c1 != 0) || (s > 255);
        o1 = s % 256;
      end
      9:  o1 = 255 - a;
      10: o1 = a & b;
      11: o1 = a | b;
      12: o1 = a ^ b;
      13: o1 = (a * 2) % 256 + a / 128;
      14: begin o1 = (a * 2) % 256 + ci; cy = (a >= 128); end
      15: o1 = a / 2 + (a % 2) * 128;
      16: begin o1 = a / 2 + ci * 128; cy = (a % 2) == 1; end
      17: o1 = (a % 16) * 16 + a / 16;
      18: cy = c & bi;
      19: cy = c | bi;
      20: cy = c & ~bi;
      21: cy = c | ~bi;
      default: ;
    endcase
    return {8'(o1), 8'(o2), cy, ac, ov};
  endfunction

  function automatic logic [18:0] dut_res();
    return {bus.op_out_1, bus.op_out_2, bus.carry_out, bus.aux_carry_out, bus.overflow_out};
  endfunction

  // Expected registered result for the inputs present at this edge.
  always @(posedge clock) begin
    if (reset)
      exp_res <= model(int'(bus.alu_opcode), int'(bus.op_in_1), int'(bus.op_in_2),
                       bus.carry_in, bus.aux_carry_in, bus.bit_in);
    else
      exp_res <= '0;
  end

  // Per-cycle comparison, half a cycle after the active edge.
  always @(negedge clock) begin
    logic [18:0] want;
    want = reset ? exp_res : '0;
    vectors++;
    if (dut_res() !== want) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t opc=%0d got %h want %h (out1,out2,cy,ac,ov)",
               $time, bus.alu_opcode, dut_res(), want);
    end
  end

  task automatic drive(input int opc, input int a, input int b,
                       input bit c, input bit acb, input bit bi);
    bus.alu_opcode   = 5'(opc);
    bus.op_in_1      = 8'(a);
    bus.op_in_2      = 8'(b);
    bus.carry_in     = c;
    bus.aux_carry_in = acb;
    bus.bit_in       = bi;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pin(input string name, input int o1, input int o2,
                     input bit cy, input bit ac, input bit ov);
    logic [18:0] want;
    want = {8'(o1), 8'(o2), cy, ac, ov};
    vectors++;
    if (dut_res() !== want) begin
      miscompares++;
      $display("FAIL %s: got out1=%h out2=%h cy=%b ac=%b ov=%b, want out1=%h out2=%h cy=%b ac=%b ov=%b",
               name, bus.op_out_1, bus.op_out_2, bus.carry_out, bus.aux_carry_out,
               bus.overflow_out, want[18:11], want[10:3], want[2], want[1], want[0]);
    end
  endtask

  logic [7:0] tab_a [8] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h99, 8'h0F, 8'hA5, 8'hC8};
  logic [7:0] tab_b [8] = '{8'h00, 8'hFF, 8'h80, 8'h80, 8'h01, 8'h01, 8'h5A, 8'h0D};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.alu_opcode = '0; bus.op_in_1 = '0; bus.op_in_2 = '0;
    bus.carry_in = 1'b0; bus.aux_carry_in = 1'b0; bus.bit_in = 1'b0;
    repeat (2) @(negedge clock);
    pin("reset_state", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Opcode sweep with fixed operands.
    for (int op = 0; op < 18; op++) begin
      drive(op, 'h40, 'h20, 1, 0, 1);
      case (op)
        1:  pin("sweep_ADD",  'h60, 0, 0, 0, 0);
        2:  pin("sweep_ADDC", 'h61, 0, 0, 0, 0);
        3:  pin("sweep_SUBB", 'h1F, 0, 0, 1, 0);
        4:  pin("sweep_INC",  'h41, 0, 1, 0, 0);
        8:  pin("sweep_DA",   'hA0, 0, 1, 0, 0);
        10: pin("sweep_ANL",  'h00, 0, 1, 0, 0);
        11: pin("sweep_ORL",  'h60, 0, 1, 0, 0);
        14: pin("sweep_RLC",  'h81, 0, 0, 0, 0);
        16: pin("sweep_RRC",  'hA0, 0, 0, 0, 0);
        17: pin("sweep_SWAP", 'h04, 0, 1, 0, 0);
        default: ;
      endcase
    end

    drive(1, 'h7F, 'h01, 0, 0, 0); pin("ADD_7F_01", 'h80, 0, 0, 1, 1);
    drive(1, 'hFF, 'h01, 0, 0, 0); pin("ADD_FF_01", 'h00, 0, 1, 1, 0);

`ifdef ALU_MULDIV_EN
    drive(6, 'h40, 'h20, 1, 0, 0); pin("MUL_40_20", 'h00, 'h08, 0, 0, 1);
    drive(7, 'h40, 'h20, 1, 0, 0); pin("DIV_40_20", 'h02, 'h00, 0, 0, 0);
    drive(7, 'h40, 'h00, 1, 0, 0); pin("DIV_by_0",  'hFF, 'hFF, 0, 0, 1);
`else
    drive(6, 'h40, 'h20, 1, 0, 0); pin("MUL_as_NOP", 'h40, 0, 1, 0, 0);
    drive(7, 'h40, 'h00, 1, 0, 0); pin("DIV_as_NOP", 'h40, 0, 1, 0, 0);
`endif

    drive(8, 'h9A, 'h00, 0, 0, 0); pin("DA_9A", 'h00, 0, 1, 0, 0);
    drive(8, 'h15, 'h00, 0, 1, 0); pin("DA_15_ac", 'h1B, 0, 0, 1, 0);

    drive(18, 'h5A, 'h00, 1, 0, 0); pin("ANL_C_bit",  'h5A, 0, 0, 0, 0);
    drive(20, 'h5A, 'h00, 1, 0, 0); pin("ANL_C_nbit", 'h5A, 0, 1, 0, 0);
    drive(19, 'h5A, 'h00, 1, 0, 0); pin("ORL_C_bit",  'h5A, 0, 1, 0, 0);
    drive(21, 'h5A, 'h00, 0, 0, 0); pin("ORL_C_nbit", 'h5A, 0, 1, 0, 0);

    drive(25, 'h33, 'h44, 1, 1, 0); pin("reserved_25", 'h33, 0, 1, 1, 0);

    // Reset asserted mid-sweep, then released.
    for (int op = 0; op < 4; op++) drive(op, 'h40, 'h20, 1, 0, 1);
    #2 reset = 1'b0;
    #1 pin("async_reset", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 pin("held_after_release", 0, 0, 0, 0, 0);
    drive(4, 'h40, 'h20, 1, 0, 1); pin("first_after_release", 'h41, 0, 1, 0, 0);

    // Operand table across every opcode, checked by the model each cycle.
    for (int i = 0; i < 8; i++)
      for (int op = 0; op < 32; op++)
        drive(op, int'(tab_a[i]), int'(tab_b[i]), (i % 2) == 1, (op % 3) == 0, (i % 3) == 1);

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
